// File: rtl/i2c_write_master_if.sv
// rtl/i2c_write_master_if.sv - sequencer-side request/status bundle for i2c_write_master
// master: the init sequencer that issues writes; slave: the I2C write engine.
interface i2c_write_master_if;
  logic       start;
  logic [7:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] data;
  logic       ready_out;
  logic       done;
  logic       ack_error;
  logic [7:0] states;

  modport master (
    output start, dev_addr, reg_addr, data,
    input  ready_out, done, ack_error, states
  );

  modport slave (
    input  start, dev_addr, reg_addr, data,
    output ready_out, done, ack_error, states
  );
endinterface

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - single-frame I2C byte write (START, dev, reg, data, STOP)
// SCL is four quarter-ticks per bit; SCL/SDA are registered from the next-state decode.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic                  clk_in,
  input  logic                  reset,
  i2c_write_master_if.slave     ctrl,
  inout  wire                   i2c_sda,
  output logic                  i2c_scl
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BIT   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  qtr, qtr_n;
  logic [3:0]  bit_idx, bit_n;
  logic [1:0]  byte_idx, byte_n;
  logic [23:0] shreg, shreg_n;
  logic        ready_q, ready_n;
  logic        done_q, done_n;
  logic        err_q, err_n;
  logic        scl_q, scl_n;
  logic        sda_low_q, sda_low_n;
  logic        tick;

  assign tick = (cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      qtr       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      qtr       <= qtr_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      shreg     <= shreg_n;
      ready_q   <= ready_n;
      done_q    <= done_n;
      err_q     <= err_n;
      scl_q     <= scl_n;
      sda_low_q <= sda_low_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    qtr_n     = qtr;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    shreg_n   = shreg;
    ready_n   = ready_q;
    done_n    = 1'b0;
    err_n     = err_q;
    scl_n     = 1'b1;
    sda_low_n = 1'b0;

    // Counter idles at 0 so the first quarter starts exactly at accept.
    if (state != ST_IDLE) begin
      cnt_n = tick ? 16'd0 : cnt + 16'd1;
    end

    case (state)
      ST_IDLE: begin
        if (ctrl.start) begin
          state_n = ST_START;
          qtr_n   = 2'd0;
          bit_n   = 4'd0;
          byte_n  = 2'd0;
          shreg_n = {ctrl.dev_addr & 8'hFE, ctrl.reg_addr, ctrl.data};
          err_n   = 1'b0;
          ready_n = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == 2'd3) begin
            state_n = ST_BIT;
          end
        end
      end
      ST_BIT: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == 2'd2 && bit_idx == 4'd8 && i2c_sda) begin
            err_n = 1'b1;
          end
          if (qtr == 2'd3) begin
            if (bit_idx != 4'd8) begin
              bit_n   = bit_idx + 4'd1;
              shreg_n = {shreg[22:0], 1'b0};
            end else if (err_q || byte_idx == 2'd2) begin
              state_n = ST_STOP;
              bit_n   = 4'd0;
            end else begin
              bit_n  = 4'd0;
              byte_n = byte_idx + 2'd1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == 2'd3) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            ready_n = 1'b1;
            bit_n   = 4'd0;
            byte_n  = 2'd0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Pin levels follow the state being entered, so they line up with the quarter.
    case (state_n)
      ST_START: sda_low_n = qtr_n[1];
      ST_BIT: begin
        scl_n     = qtr_n[1];
        sda_low_n = (bit_n != 4'd8) && !shreg_n[23];
      end
      ST_STOP: begin
        scl_n     = qtr_n[1];
        sda_low_n = (qtr_n != 2'd3);
      end
      default: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

  assign ctrl.ready_out = ready_q;
  assign ctrl.done      = done_q;
  assign ctrl.ack_error = err_q;
  assign ctrl.states    = {byte_idx, bit_idx, state};
  assign i2c_scl        = scl_q;
  assign i2c_sda        = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - bench for i2c_write_master with an I2C slave model and byte scoreboard
// Wire bytes are decoded from SCL/SDA and popped against bytes queued at request time.
module tb_i2c_write_master;

  localparam int unsigned DIV = 4;

  logic clk_in;
  logic reset;
  logic i2c_scl;
  wire  sda_bus;
  logic ack_drv;

  i2c_write_master_if ctrl_if ();

  i2c_write_master #(.CLK_DIV(DIV)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .ctrl    (ctrl_if.slave),
    .i2c_sda (sda_bus),
    .i2c_scl (i2c_scl)
  );

  pullup pu_sda (sda_bus);
  assign sda_bus = ack_drv ? 1'b0 : 1'bz;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp;
  int n_fail;
  int stop_cnt;
  int nack_idx;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    int         nack;
    int         cycles;
    logic       err;
  } vec_t;

  vec_t vecs[6];
  vec_t rom[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input vec_t v);
    for (int b = 0; b < 3; b++) begin
      if (b <= v.nack) begin
        exp_q.push_back(b == 0 ? (v.dev & 8'hFE) : (b == 1 ? v.rg : v.dat));
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 2000 && !ctrl_if.done) begin
      @(posedge clk_in);
      #1;
      n++;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int stops0;
    nack_idx = v.nack;
    stops0   = stop_cnt;
    push_frame(v);
    @(negedge clk_in);
    ctrl_if.dev_addr = v.dev;
    ctrl_if.reg_addr = v.rg;
    ctrl_if.data     = v.dat;
    ctrl_if.start    = 1'b1;
    @(posedge clk_in);
    #1;
    ctrl_if.start    = 1'b0;
    ctrl_if.dev_addr = 8'($urandom);
    ctrl_if.reg_addr = 8'($urandom);
    ctrl_if.data     = 8'($urandom);
    check("ready_drop", ctrl_if.ready_out, 0);
    check("err_clear_on_accept", ctrl_if.ack_error, 0);
    wait_done(n);
    check("done_latency", n, v.cycles);
    check("ack_error", ctrl_if.ack_error, v.err);
    check("ready_back", ctrl_if.ready_out, 1);
    check("stop_seen", stop_cnt - stops0, 1);
    @(posedge clk_in);
    #1;
    check("done_width", ctrl_if.done, 0);
    check("idle_states", ctrl_if.states, 0);
    check("idle_scl", i2c_scl, 1);
    check("idle_sda", sda_bus, 1);
  endtask

  // Slave model: decodes START/STOP and bytes, drives ACK unless told to NACK.
  initial begin : slave_monitor
    logic ps, pd, s, d;
    int bn, byn;
    logic [7:0] sh;
    logic [7:0] e;
    logic inf;
    ps = 1'b1; pd = 1'b1; bn = 0; byn = 0; sh = '0; inf = 1'b0; ack_drv = 1'b0;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        inf = 1'b0; ack_drv = 1'b0; ps = 1'b1; pd = 1'b1;
      end else begin
        s = i2c_scl;
        d = sda_bus;
        if (s && ps && pd && !d) begin
          inf = 1'b1; bn = 0; byn = 0;
        end else if (s && ps && !pd && d) begin
          inf = 1'b0;
          stop_cnt++;
        end else if (inf && s && !ps) begin
          if (bn < 8) begin
            sh = {sh[6:0], d};
            bn++;
            if (bn == 8) begin
              n_cmp++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wire_byte: got %02h expected no byte", sh);
              end else begin
                e = exp_q.pop_front();
                if (sh !== e) begin
                  n_fail++;
                  $display("FAIL wire_byte: got %02h expected %02h", sh, e);
                end
              end
            end
          end else begin
            bn = 0;
            byn++;
          end
        end else if (inf && !s && ps) begin
          ack_drv = (bn == 8) && (byn != nack_idx);
        end
        ps = s;
        pd = d;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    n_cmp = 0; n_fail = 0; stop_cnt = 0; nack_idx = 3;
    vecs[0] = '{8'h72, 8'h41, 8'h10, 3, 464, 1'b0};
    vecs[1] = '{8'h73, 8'h41, 8'h10, 3, 464, 1'b0};
    vecs[2] = '{8'h72, 8'h41, 8'h10, 1, 320, 1'b1};
    vecs[3] = '{8'h5A, 8'hA5, 8'hFF, 0, 176, 1'b1};
    vecs[4] = '{8'h3C, 8'hC3, 8'h00, 2, 464, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 8'h81, 3, 464, 1'b0};
    rom[0]  = '{8'h72, 8'h08, 8'h35, 3, 464, 1'b0};
    rom[1]  = '{8'h72, 8'h96, 8'h20, 3, 464, 1'b0};
    rom[2]  = '{8'h7A, 8'h94, 8'hC0, 3, 464, 1'b0};

    ctrl_if.start = 1'b0; ctrl_if.dev_addr = '0; ctrl_if.reg_addr = '0; ctrl_if.data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_ready", ctrl_if.ready_out, 1);
    check("rst_done", ctrl_if.done, 0);
    check("rst_err", ctrl_if.ack_error, 0);
    check("rst_states", ctrl_if.states, 0);
    check("rst_scl", i2c_scl, 1);
    check("rst_sda", sda_bus, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // start held high: three back-to-back frames from a ROM-like source
    nack_idx = 3;
    for (int k = 0; k < 3; k++) push_frame(rom[k]);
    @(negedge clk_in);
    ctrl_if.dev_addr = rom[0].dev; ctrl_if.reg_addr = rom[0].rg; ctrl_if.data = rom[0].dat;
    ctrl_if.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in);
      #1;
      check("b2b_accept", ctrl_if.ready_out, 0);
      if (k < 2) begin
        ctrl_if.dev_addr = rom[k+1].dev; ctrl_if.reg_addr = rom[k+1].rg; ctrl_if.data = rom[k+1].dat;
      end else begin
        ctrl_if.start = 1'b0;
      end
      wait_done(n);
      check("b2b_latency", n, 464);
      check("b2b_ready_gap", ctrl_if.ready_out, 1);
    end
    @(posedge clk_in);
    #1;
    check("b2b_no_repeat", ctrl_if.ready_out, 1);

    // reset at tick 50 while byte 1 is on the wire
    nack_idx = 3;
    exp_q.push_back(8'h72);
    @(negedge clk_in);
    ctrl_if.dev_addr = 8'h72; ctrl_if.reg_addr = 8'h41; ctrl_if.data = 8'h10;
    ctrl_if.start = 1'b1;
    @(posedge clk_in);
    #1;
    ctrl_if.start = 1'b0;
    repeat (50 * DIV - 1) @(posedge clk_in);
    #2;
    check("pre_reset_busy", ctrl_if.ready_out, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_scl", i2c_scl, 1);
    check("mid_rst_sda", sda_bus, 1);
    check("mid_rst_ready", ctrl_if.ready_out, 1);
    check("mid_rst_states", ctrl_if.states, 0);
    check("mid_rst_done", ctrl_if.done, 0);
    repeat (3) @(negedge clk_in);
    check("mid_rst_no_done", ctrl_if.done, 0);
    check("mid_rst_queue", exp_q.size(), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    run_txn(vecs[0]);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
